// File: rtl/mux4_rr_feeder_if.sv
// mux4_rr_feeder_if
//   Request/data/grant bundle between four sources, the round-robin feeder
//   and the downstream valid/ready consumer.
//   Signals:
//     req[3:0]              per-channel request (bit 0 = A ... bit 3 = D)
//     din_a..din_d          per-channel data, DATA_W bits each
//     gnt[3:0]              one-cycle one-hot grant acknowledge
//     sel[1:0]              select code of the captured channel
//     y_data, y_valid       captured word and its valid flag
//     y_ready               downstream accept
//   Modports:
//     master : sources + downstream sink (drive req/din/y_ready)
//     slave  : the feeder (drives gnt/sel/y_data/y_valid)
interface mux4_rr_feeder_if #(
    parameter int DATA_W = 1
);
    logic [3:0]        req;
    logic [DATA_W-1:0] din_a;
    logic [DATA_W-1:0] din_b;
    logic [DATA_W-1:0] din_c;
    logic [DATA_W-1:0] din_d;
    logic [3:0]        gnt;
    logic [1:0]        sel;
    logic [DATA_W-1:0] y_data;
    logic              y_valid;
    logic              y_ready;

    modport master (
        output req, din_a, din_b, din_c, din_d, y_ready,
        input  gnt, sel, y_data, y_valid
    );

    modport slave (
        input  req, din_a, din_b, din_c, din_d, y_ready,
        output gnt, sel, y_data, y_valid
    );
endinterface

// File: rtl/mux4_rr_feeder.sv
// mux4_rr_feeder
//   Four-channel round-robin arbiter with a capture register feeding the
//   4-to-1 select mux. The winning channel's data is latched and presented
//   downstream on a valid/ready handshake; the winner gets a one-cycle
//   one-hot grant acknowledge.
//   Ports:
//     clk         single clock, all state on rising edge
//     rst_n       synchronous active-low reset
//     bus         mux4_rr_feeder_if.slave (req, din_a..d, gnt, sel,
//                 y_data, y_valid, y_ready)
//     xfer_count  16-bit saturating handshake counter, present only when
//                 MUX4_RR_FEEDER_STATS_EN is defined
module mux4_rr_feeder #(
    parameter int DATA_W = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mux4_rr_feeder_if.slave      bus
`ifdef MUX4_RR_FEEDER_STATS_EN
    ,
    output logic [15:0]          xfer_count
`endif
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0]        state;
    logic [1:0]        last;
    logic [3:0]        gnt_q;
    logic [1:0]        sel_q;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;

    logic [3:0]        eligible;
    logic              found;
    logic [1:0]        win_idx;
    logic [1:0]        idx;
    logic [DATA_W-1:0] win_data;
    logic              handshake;
    logic              cap_opp;

    // A channel granted this cycle is masked so a source still holding req
    // for one more cycle is not granted twice.
    assign eligible  = bus.req & ~gnt_q;
    assign handshake = valid_q & bus.y_ready;
    assign cap_opp   = (state == IDLE) || handshake;

    // Search starts just after the last winner and wraps 3 -> 0.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        idx     = '0;
        for (int unsigned i = 1; i <= 4; i++) begin
            idx = last + 2'(i);
            if (!found && eligible[idx]) begin
                found   = 1'b1;
                win_idx = idx;
            end
        end
    end

    always_comb begin
        win_data = '0;
        case (win_idx)
            2'd0:    win_data = bus.din_a;
            2'd1:    win_data = bus.din_b;
            2'd2:    win_data = bus.din_c;
            default: win_data = bus.din_d;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            last    <= 2'd3;
            gnt_q   <= '0;
            sel_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            gnt_q <= '0;
            if (cap_opp) begin
                if (found) begin
                    data_q  <= win_data;
                    sel_q   <= win_idx;
                    gnt_q   <= 4'b0001 << win_idx;
                    last    <= win_idx;
                    valid_q <= 1'b1;
                    state   <= HOLD;
                end else if (state == HOLD) begin
                    valid_q <= 1'b0;
                    state   <= IDLE;
                end
            end
        end
    end

`ifdef MUX4_RR_FEEDER_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xfer_count <= '0;
        end else if (handshake && (xfer_count != 16'hFFFF)) begin
            xfer_count <= xfer_count + 16'd1;
        end
    end
`endif

    assign bus.gnt     = gnt_q;
    assign bus.sel     = sel_q;
    assign bus.y_data  = data_q;
    assign bus.y_valid = valid_q;
endmodule

// File: tb/tb_mux4_rr_feeder.sv
// tb_mux4_rr_feeder
//   Directed table-driven bench for mux4_rr_feeder (DATA_W = 1), plus
//   hand-written sequences for backpressure with a bounded wait and, when
//   MUX4_RR_FEEDER_STATS_EN is defined, the handshake counter.
module tb_mux4_rr_feeder;
    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;

`ifdef MUX4_RR_FEEDER_STATS_EN
    logic [15:0] xfer_count;
`endif

    mux4_rr_feeder_if #(.DATA_W(1)) bus ();

    mux4_rr_feeder #(.DATA_W(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef MUX4_RR_FEEDER_STATS_EN
        ,
        .xfer_count (xfer_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic [3:0] din;    // {d, c, b, a}
        logic       rdy;
        logic [3:0] e_gnt;
        logic [1:0] e_sel;
        logic       e_yd;
        logic       e_yv;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic r, input logic [3:0] q, input logic [3:0] d, input logic y);
        rst_n       = r;
        bus.req     = q;
        bus.din_a   = d[0];
        bus.din_b   = d[1];
        bus.din_c   = d[2];
        bus.din_d   = d[3];
        bus.y_ready = y;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int gnt_pulses;
        bit seen;
        pass_cnt  = 0;
        total_cnt = 0;

        // reset, single request
        vecs[0]  = '{1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 4'b0100, 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1};
        vecs[3]  = '{1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd2, 1'b1, 1'b0};
        // round robin from a fresh reset, wrap 3 -> 0
        vecs[4]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1};
        vecs[6]  = '{1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1};
        vecs[7]  = '{1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1};
        vecs[8]  = '{1'b1, 4'b1111, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b1};
        vecs[9]  = '{1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1};
        // drain, then backpressure on B while D requests
        vecs[10] = '{1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 4'b0010, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b1};
        vecs[12] = '{1'b1, 4'b1000, 4'b0000, 1'b0, 4'b0000, 2'd1, 1'b1, 1'b1};
        vecs[13] = '{1'b1, 4'b1000, 4'b0000, 1'b0, 4'b0000, 2'd1, 1'b1, 1'b1};
        vecs[14] = '{1'b1, 4'b1000, 4'b0000, 1'b0, 4'b0000, 2'd1, 1'b1, 1'b1};
        vecs[15] = '{1'b1, 4'b1000, 4'b0000, 1'b0, 4'b0000, 2'd1, 1'b1, 1'b1};
        vecs[16] = '{1'b1, 4'b1000, 4'b0000, 1'b1, 4'b1000, 2'd3, 1'b0, 1'b1};
        vecs[17] = '{1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b1};
        // reset mid-HOLD, A first afterwards
        vecs[18] = '{1'b0, 4'b1111, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[19] = '{1'b1, 4'b1111, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b1};
        vecs[20] = '{1'b1, 4'b1111, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b1, 1'b1};
        // gnt mask: a lone held request is not granted twice in a row
        vecs[21] = '{1'b1, 4'b0001, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1};
        vecs[22] = '{1'b1, 4'b0001, 4'b0001, 1'b1, 4'b0000, 2'd0, 1'b1, 1'b0};
        vecs[23] = '{1'b1, 4'b0001, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1};

        drive(1'b0, 4'b0000, 4'b0000, 1'b0);
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst_n, vecs[i].req, vecs[i].din, vecs[i].rdy);
            tick();
            check($sformatf("v%0d_gnt", i), int'(bus.gnt), int'(vecs[i].e_gnt));
            check($sformatf("v%0d_sel", i), int'(bus.sel), int'(vecs[i].e_sel));
            check($sformatf("v%0d_ydata", i), int'(bus.y_data), int'(vecs[i].e_yd));
            check($sformatf("v%0d_yvalid", i), int'(bus.y_valid), int'(vecs[i].e_yv));
        end

        // Bounded wait for a capture, then one gnt pulse under backpressure.
        drive(1'b0, 4'b0000, 4'b0000, 1'b0);
        tick();
        drive(1'b1, 4'b0100, 4'b1111, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            if (bus.y_valid) seen = 1'b1;
        end
        check("wait_valid", int'(seen), 1);
        gnt_pulses = (bus.gnt != 4'b0000) ? 1 : 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.gnt != 4'b0000) gnt_pulses++;
        end
        check("bp_gnt_pulses", gnt_pulses, 1);
        check("bp_sel", int'(bus.sel), 2);
        check("bp_valid", int'(bus.y_valid), 1);
        drive(1'b1, 4'b0000, 4'b0000, 1'b1);
        tick();
        check("bp_drain_valid", int'(bus.y_valid), 0);

`ifdef MUX4_RR_FEEDER_STATS_EN
        drive(1'b0, 4'b0000, 4'b0000, 1'b0);
        tick();
        check("stat_reset", int'(xfer_count), 0);
        drive(1'b1, 4'b1111, 4'b1111, 1'b0);
        tick();
        drive(1'b1, 4'b1111, 4'b1111, 1'b1);
        repeat (3) tick();
        drive(1'b1, 4'b1111, 4'b1111, 1'b0);
        tick();
        check("stat_three", int'(xfer_count), 3);
        drive(1'b0, 4'b1111, 4'b1111, 1'b0);
        tick();
        check("stat_cleared", int'(xfer_count), 0);
        drive(1'b1, 4'b1111, 4'b1111, 1'b0);
        tick();
        drive(1'b1, 4'b1111, 4'b1111, 1'b1);
        tick();
        drive(1'b1, 4'b1111, 4'b1111, 1'b0);
        tick();
        check("stat_one", int'(xfer_count), 1);
        drive(1'b1, 4'b1111, 4'b1111, 1'b1);
        repeat (65540) tick();
        check("stat_saturate", int'(xfer_count), 16'hFFFF);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
